// File: rtl/seg7_capture.sv
// Seven-segment display reader: debounces two active-low digit patterns,
// decodes them to BCD and publishes values with range/sequence checks.
//
// Ports:
//   CLOCK_50  in   clock, rising edge
//   SW        in   synchronous active-high reset
//   HEX1      in   [6:0] tens pattern, active-low, bit6..0 = g..a
//   HEX0      in   [6:0] units pattern, same encoding
//   out_ready in   consumer accepts bcd_* when high with out_valid
//   bcd_tens  out  [3:0] decoded tens digit
//   bcd_units out  [3:0] decoded units digit
//   out_valid out  bcd_* hold a value not yet accepted
//   seg_err   out  pulse: accepted pattern illegal or above MAX_COUNT
//   seq_err   out  pulse: published value breaks the count sequence
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_COUNT     = 60
) (
  input  logic       CLOCK_50,
  input  logic       SW,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX0,
  input  logic       out_ready,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       out_valid,
  output logic       seg_err,
  output logic       seq_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {
    WAIT,
    PUBLISH
  } state_t;

  state_t state, state_n;

  logic [13:0]   hex_q;
  logic [13:0]   last_pat;
  logic [CW-1:0] stab_cnt;
  logic          have_prev;
  logic [6:0]    prev;

  // {legal, digit}
  function automatic logic [4:0] dec(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b1000000: r = 5'b1_0000;
      7'b1111001: r = 5'b1_0001;
      7'b0100100: r = 5'b1_0010;
      7'b0110000: r = 5'b1_0011;
      7'b0011001: r = 5'b1_0100;
      7'b0010010: r = 5'b1_0101;
      7'b0000010: r = 5'b1_0110;
      7'b1111000: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0010000: r = 5'b1_1001;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [4:0] dt, du;
  logic [6:0] value;
  logic       stable, accept, good, publish, bad, release_o, seq_ok;

  assign dt     = dec(hex_q[13:7]);
  assign du     = dec(hex_q[6:0]);
  assign value  = {3'b000, dt[3:0]} * 7'd10 + {3'b000, du[3:0]};
  assign stable = (stab_cnt == CW'(STABLE_CYCLES));
  assign accept = stable && (hex_q != last_pat) && (state == WAIT);
  assign good   = dt[4] && du[4] && (value <= 7'(MAX_COUNT));

  // A return to zero is always legal: the counter may have been reset.
  assign seq_ok = !have_prev
               || (value == prev + 7'd1)
               || ((prev == 7'(MAX_COUNT)) && (value == 7'd0))
               || (value == 7'd0);

  always_comb begin
    state_n   = state;
    publish   = 1'b0;
    bad       = 1'b0;
    release_o = 1'b0;
    unique case (state)
      WAIT: begin
        if (accept && good) begin
          publish = 1'b1;
          state_n = PUBLISH;
        end else if (accept) begin
          bad = 1'b1;
        end
      end
      PUBLISH: begin
        if (out_valid && out_ready) begin
          release_o = 1'b1;
          state_n   = WAIT;
        end
      end
      default: state_n = WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (SW) state <= WAIT;
    else    state <= state_n;
  end

  // Input sampling runs through reset so debounce starts from the live bus.
  always_ff @(posedge CLOCK_50) begin
    hex_q <= {HEX1, HEX0};
    if (SW)
      stab_cnt <= '0;
    else if ({HEX1, HEX0} != hex_q)
      stab_cnt <= '0;
    else if (!stable)
      stab_cnt <= stab_cnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (SW) begin
      last_pat  <= 14'h3FFF;
      bcd_tens  <= 4'd0;
      bcd_units <= 4'd0;
      out_valid <= 1'b0;
      seg_err   <= 1'b0;
      seq_err   <= 1'b0;
      have_prev <= 1'b0;
      prev      <= 7'd0;
    end else begin
      seg_err <= bad;
      seq_err <= 1'b0;
      if (accept)
        last_pat <= hex_q;
      if (publish) begin
        bcd_tens  <= dt[3:0];
        bcd_units <= du[3:0];
        out_valid <= 1'b1;
        seq_err   <= !seq_ok;
        have_prev <= 1'b1;
        prev      <= value;
      end else if (release_o) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture.
// Drives digit patterns on the falling edge and checks after it.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       sw;
  logic [6:0] hex1, hex0;
  logic       rdy;
  logic [3:0] bt, bu;
  logic       ov, sege, seqe;

  int n_chk = 0;
  int n_fail = 0;

  int pubs = 0, segs = 0, seqs = 0;
  logic ov_d = 1'b0;
  logic pub_seq = 1'b0;
  logic [7:0] pq[$];

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4), .MAX_COUNT(60)) dut (
    .CLOCK_50 (clk),
    .SW       (sw),
    .HEX1     (hex1),
    .HEX0     (hex0),
    .out_ready(rdy),
    .bcd_tens (bt),
    .bcd_units(bu),
    .out_valid(ov),
    .seg_err  (sege),
    .seq_err  (seqe)
  );

  always @(negedge clk) begin
    if (ov && !ov_d) begin
      pubs++;
      pq.push_back({bt, bu});
      pub_seq = seqe;
    end
    if (sege) segs++;
    if (seqe) seqs++;
    ov_d = ov;
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic put(input int t, input int u);
    hex1 = seg(t);
    hex0 = seg(u);
  endtask

  task automatic do_reset();
    sw = 1'b1;
    step(2);
    sw = 1'b0;
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    put(0, 0);
    do_reset();
    n_chk++;
    if (ov !== 1'b0 || bt !== 4'd0 || bu !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b bcd=%0d/%0d want 0 0/0", ov, bt, bu);
    end
    step(4);
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: ov=%b want 0", ov);
    end
    step(1);
    n_chk++;
    if (ov !== 1'b1 || bt !== 4'd0 || bu !== 4'd0 || seqe !== 1'b0) begin
      n_fail++;
      $display("FAIL first_publish: ov=%b bcd=%0d/%0d seq=%b want 1 0/0 0",
               ov, bt, bu, seqe);
    end
    step(1);
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_drop: ov=%b want 0", ov);
    end
  endtask

  task automatic test_glitch();
    int p0, s0;
    put(0, 2);
    step(8);
    p0 = pubs;
    s0 = segs;
    put(0, 3);
    step(2);
    put(0, 2);
    step(8);
    n_chk++;
    if (pubs - p0 !== 0 || segs - s0 !== 0) begin
      n_fail++;
      $display("FAIL glitch: pubs=%0d segs=%0d want 0 0", pubs - p0, segs - s0);
    end
  endtask

  task automatic test_wrap();
    int p0, q0, b;
    put(5, 8);
    do_reset();
    p0 = pubs;
    q0 = seqs;
    b = pq.size();
    step(8);
    put(5, 9);
    step(8);
    put(6, 0);
    step(8);
    put(0, 0);
    step(8);
    n_chk++;
    if (pubs - p0 !== 4 || seqs - q0 !== 0) begin
      n_fail++;
      $display("FAIL wrap_counts: pubs=%0d seqs=%0d want 4 0",
               pubs - p0, seqs - q0);
    end
    n_chk++;
    if (pq.size() < b + 4) begin
      n_fail++;
      $display("FAIL wrap_values: only %0d values want 4", pq.size() - b);
    end else if (pq[b] !== 8'h58 || pq[b+1] !== 8'h59 ||
                 pq[b+2] !== 8'h60 || pq[b+3] !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_values: %h %h %h %h want 58 59 60 00",
               pq[b], pq[b+1], pq[b+2], pq[b+3]);
    end
  endtask

  task automatic test_seq_break();
    int p0, q0, s0;
    put(0, 5);
    do_reset();
    step(8);
    p0 = pubs;
    q0 = seqs;
    put(0, 7);
    step(8);
    n_chk++;
    if (pubs - p0 !== 1 || pq[$] !== 8'h07 || pub_seq !== 1'b1 ||
        seqs - q0 !== 1) begin
      n_fail++;
      $display("FAIL seq_break: pubs=%0d val=%h seq_at_pub=%b seqs=%0d want 1 07 1 1",
               pubs - p0, pq[$], pub_seq, seqs - q0);
    end
    p0 = pubs;
    s0 = segs;
    put(6, 1);
    step(8);
    n_chk++;
    if (pubs - p0 !== 0 || segs - s0 !== 1) begin
      n_fail++;
      $display("FAIL over_max: pubs=%0d segs=%0d want 0 1", pubs - p0, segs - s0);
    end
  endtask

  task automatic test_illegal();
    int p0, s0;
    p0 = pubs;
    s0 = segs;
    hex1 = seg(0);
    hex0 = 7'b0001000;
    step(8);
    n_chk++;
    if (pubs - p0 !== 0 || segs - s0 !== 1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pat: pubs=%0d segs=%0d ov=%b want 0 1 0",
               pubs - p0, segs - s0, ov);
    end
  endtask

  task automatic test_backpressure();
    int q0;
    rdy = 1'b0;
    put(1, 2);
    do_reset();
    step(8);
    n_chk++;
    if (ov !== 1'b1 || bt !== 4'd1 || bu !== 4'd2) begin
      n_fail++;
      $display("FAIL hold_12: ov=%b bcd=%0d/%0d want 1 1/2", ov, bt, bu);
    end
    q0 = seqs;
    put(1, 3);
    step(8);
    n_chk++;
    if (ov !== 1'b1 || bt !== 4'd1 || bu !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_stable: ov=%b bcd=%0d/%0d want 1 1/2", ov, bt, bu);
    end
    rdy = 1'b1;
    step(2);
    n_chk++;
    if (ov !== 1'b1 || bt !== 4'd1 || bu !== 4'd3 || seqs - q0 !== 0) begin
      n_fail++;
      $display("FAIL release_13: ov=%b bcd=%0d/%0d seqs=%0d want 1 1/3 0",
               ov, bt, bu, seqs - q0);
    end
  endtask

  task automatic test_reset_pending();
    int p0, q0;
    rdy = 1'b0;
    put(2, 0);
    step(8);
    n_chk++;
    if (ov !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_20: ov=%b want 1", ov);
    end
    sw = 1'b1;
    step(1);
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: ov=%b want 0", ov);
    end
    sw = 1'b0;
    rdy = 1'b1;
    p0 = pubs;
    q0 = seqs;
    step(8);
    n_chk++;
    if (pubs - p0 !== 1 || seqs - q0 !== 0 || pq[$] !== 8'h20) begin
      n_fail++;
      $display("FAIL post_reset_pub: pubs=%0d seqs=%0d val=%h want 1 0 20",
               pubs - p0, seqs - q0, pq[$]);
    end
  endtask

  initial begin
    sw = 1'b1;
    rdy = 1'b1;
    hex1 = 7'h7F;
    hex0 = 7'h7F;
    test_reset();
    test_glitch();
    test_wrap();
    test_seq_break();
    test_illegal();
    test_backpressure();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
